// File: rtl/dct_quant_zigzag_pkg.sv
// Shared constants for dct_quant_zigzag: width defaults, JPEG luminance
// quantizer table, zigzag-to-raster map, reciprocal table builder and FSM states.
package dct_pkg;

  localparam int unsigned COEF_W_DEF  = 12;
  localparam int unsigned Q_W_DEF     = 8;
  localparam int unsigned RECIP_W_DEF = 16;

  typedef enum logic {ST_LOAD, ST_DRAIN} state_e;

  localparam int unsigned QTAB [64] = '{
    16, 11, 10, 16,  24,  40,  51,  61,
    12, 12, 14, 19,  26,  58,  60,  55,
    14, 13, 16, 24,  40,  57,  69,  56,
    14, 17, 22, 29,  51,  87,  80,  62,
    18, 22, 37, 56,  68, 109, 103,  77,
    24, 35, 55, 64,  81, 104, 113,  92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103,  99
  };

  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef logic [63:0][31:0] recip_tab_t;

  // round(2^rw / Q); odd Q never produces an exact .5, so adding Q/2 is exact rounding
  function automatic recip_tab_t recip_table(int unsigned rw);
    recip_tab_t t;
    for (int unsigned i = 0; i < 64; i++)
      t[i] = 32'(((64'd1 << rw) + 64'(QTAB[i] / 2)) / 64'(QTAB[i]));
    return t;
  endfunction

  localparam recip_tab_t RECIP = recip_table(RECIP_W_DEF);

endpackage

// File: rtl/dct_quant_zigzag_if.sv
// Row-input / zigzag-output handshake bundle for dct_quant_zigzag.
interface dct_quant_zigzag_if
  import dct_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned Q_W    = Q_W_DEF
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [COEF_W-1:0] c0, c1, c2, c3, c4, c5, c6, c7;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [Q_W-1:0]    out_coef;
  logic [5:0]               out_index;
  logic                     out_sat;
  logic                     out_last;

  modport master (
    output in_valid, c0, c1, c2, c3, c4, c5, c6, c7, out_ready,
    input  in_ready, out_valid, out_coef, out_index, out_sat, out_last
  );

  modport slave (
    input  in_valid, c0, c1, c2, c3, c4, c5, c6, c7, out_ready,
    output in_ready, out_valid, out_coef, out_index, out_sat, out_last
  );
endinterface

// File: rtl/dct_quant_zigzag_coef_quant.sv
// Single-coefficient quantizer: reciprocal multiply, shift, saturate.
// QUANT_ROUND_EN selects round-half-up; default is floor.
module coef_quant #(
  parameter int unsigned COEF_W  = 12,
  parameter int unsigned Q_W     = 8,
  parameter int unsigned RECIP_W = 16
) (
  input  logic signed [COEF_W-1:0] coef_i,
  input  logic [RECIP_W-1:0]       recip_i,
  output logic signed [Q_W-1:0]    q_o,
  output logic                     sat_o
);
  localparam int unsigned P_W = COEF_W + RECIP_W + 2;
  localparam int unsigned S_W = P_W - RECIP_W;
  localparam logic signed [S_W-1:0] Q_MAX = {{(S_W-Q_W+1){1'b0}}, {(Q_W-1){1'b1}}};
  localparam logic signed [S_W-1:0] Q_MIN = {{(S_W-Q_W+1){1'b1}}, {(Q_W-1){1'b0}}};

  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] biased;
  logic signed [S_W-1:0] shifted;

  always_comb begin
    prod = P_W'(coef_i) * P_W'($signed({1'b0, recip_i}));
`ifdef QUANT_ROUND_EN
    biased = prod + (P_W'(1) << (RECIP_W - 1));
`else
    biased = prod;
`endif
    shifted = S_W'(biased >>> RECIP_W);
    q_o     = Q_W'(shifted);
    sat_o   = 1'b0;
    if (shifted > Q_MAX) begin
      q_o   = Q_MAX[Q_W-1:0];
      sat_o = 1'b1;
    end else if (shifted < Q_MIN) begin
      q_o   = Q_MIN[Q_W-1:0];
      sat_o = 1'b1;
    end
  end
endmodule

// File: rtl/dct_quant_zigzag.sv
// 8x8 block quantizer: loads eight rows, then streams 64 saturated coefficients
// in zigzag order. QUANT_ROUND_EN (in coef_quant) switches floor to round-half-up.
module dct_quant_zigzag
  import dct_pkg::*;
#(
  parameter int unsigned COEF_W  = COEF_W_DEF,
  parameter int unsigned Q_W     = Q_W_DEF,
  parameter int unsigned RECIP_W = RECIP_W_DEF
) (
  input logic               clk,
  input logic               reset,
  dct_quant_zigzag_if.slave bus
);
  localparam recip_tab_t RECIP_T = recip_table(RECIP_W);

  typedef struct packed {
    logic                  sat;
    logic signed [Q_W-1:0] q;
  } entry_t;

  state_e                state_q;
  logic [2:0]            row_cnt_q;
  logic [5:0]            idx_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic signed [Q_W-1:0] out_coef_q;
  logic                  out_sat_q;
  logic                  out_last_q;
  entry_t                mem_q [64];

  logic signed [COEF_W-1:0] coef [8];
  logic signed [Q_W-1:0]    qv [8];
  logic                     qs [8];
  logic                     accept;
  logic                     xfer;
  logic [5:0]               idx_d;
  entry_t                   rd_ent;

  always_comb begin
    coef[0] = bus.c0;
    coef[1] = bus.c1;
    coef[2] = bus.c2;
    coef[3] = bus.c3;
    coef[4] = bus.c4;
    coef[5] = bus.c5;
    coef[6] = bus.c6;
    coef[7] = bus.c7;
  end

  for (genvar k = 0; k < 8; k++) begin : g_col
    logic [RECIP_W-1:0] recip;
    assign recip = RECIP_W'(RECIP_T[{row_cnt_q, 3'(k)}]);
    coef_quant #(
      .COEF_W  (COEF_W),
      .Q_W     (Q_W),
      .RECIP_W (RECIP_W)
    ) u_quant (
      .coef_i  (coef[k]),
      .recip_i (recip),
      .q_o     (qv[k]),
      .sat_o   (qs[k])
    );
  end

  assign accept = bus.in_valid && in_ready_q;
  assign xfer   = out_valid_q && bus.out_ready;

  // Output registers are preloaded with the entry for the next index, so the
  // read address runs one ahead: 0 when entering DRAIN, idx+1 while draining.
  always_comb begin
    idx_d  = (state_q == ST_DRAIN) ? idx_q + 6'd1 : '0;
    rd_ent = mem_q[ZZ[idx_d]];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned k = 0; k < 8; k++)
        mem_q[{row_cnt_q, 3'(k)}] <= '{sat: qs[k], q: qv[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      row_cnt_q   <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_coef_q  <= '0;
      out_sat_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            row_cnt_q <= row_cnt_q + 3'd1;
            if (row_cnt_q == 3'd7) begin
              state_q     <= ST_DRAIN;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              idx_q       <= '0;
              out_coef_q  <= rd_ent.q;
              out_sat_q   <= rd_ent.sat;
              out_last_q  <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (xfer) begin
            if (idx_q == 6'd63) begin
              state_q     <= ST_LOAD;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              idx_q       <= '0;
              row_cnt_q   <= '0;
            end else begin
              idx_q      <= idx_d;
              out_coef_q <= rd_ent.q;
              out_sat_q  <= rd_ent.sat;
              out_last_q <= (idx_d == 6'd63);
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_coef  = out_coef_q;
  assign bus.out_index = idx_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: doc/dct_quant_zigzag.md
DCT_QUANT_ZIGZAG -- requirements
Module: dct_quant_zigzag

Interface
REQ-001 SHALL have parameter COEF_W, default 12, the signed width of an input DCT coefficient.
REQ-002 SHALL have parameter Q_W, default 8, the signed width of a quantized output coefficient.
REQ-003 SHALL have parameter RECIP_W, default 16, the fractional bits of the reciprocal quantizer table.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  one coefficient row (c0..c7) is presented.
REQ-007 in_ready  output  1  block accepts a row this cycle.
REQ-008 c0..c7  input  signed COEF_W each  coefficients of the current row, c0 = column 0.
REQ-009 out_valid  output  1  out_coef, out_index, out_sat and out_last are valid.
REQ-010 out_ready  input  1  downstream accepts the current output.
REQ-011 out_coef  output  signed Q_W  quantized coefficient in zigzag order.
REQ-012 out_index  output  6  zigzag position 0..63 of out_coef.
REQ-013 out_sat  output  1  out_coef was clipped to the Q_W range.
REQ-014 out_last  output  1  high with out_index == 63.

Function
REQ-015 SHALL implement a two-state FSM, LOAD and DRAIN; LOAD drives in_ready=1 and out_valid=0; DRAIN drives in_ready=0.
REQ-016 SHALL accept a row on each edge where in_valid && in_ready; a 3-bit row counter increments per accepted row.
REQ-017 SHALL quantize each element as q = (c * RECIP[r*8+k]) >>> RECIP_W, where RECIP = round(2^RECIP_W / Q) for the JPEG luminance table Q, using a full-width signed product.
REQ-018 SHALL saturate q to [-2^(Q_W-1), 2^(Q_W-1)-1] and store it with a saturation bit in a 64-entry buffer at address r*8+k.
REQ-019 SHALL enter DRAIN on the edge that accepts row 7; out_valid SHALL be high the next cycle with out_index=0, so latency from the last row to the first output is 1 cycle.
REQ-020 In DRAIN, out_coef SHALL be the buffer entry at ZZ[out_index], where ZZ is the standard 8x8 zigzag-to-raster map.
REQ-021 SHALL advance out_index only when out_valid && out_ready; while out_ready=0, all outputs SHALL hold stable.
REQ-022 When index 63 is transferred, SHALL return to LOAD, clear both counters and raise in_ready on the next cycle.
REQ-023 in_valid during DRAIN SHALL be ignored; no row is lost, because in_ready=0.

Reset
REQ-024 When reset is high at an edge, SHALL force LOAD, row counter 0, out_index 0, out_valid 0, out_coef 0, out_sat 0, out_last 0 and in_ready 1, leaving buffer contents undefined.
REQ-025 Reset mid-LOAD or mid-DRAIN SHALL abandon the block; the next accepted row is row 0.

Configuration
REQ-026 With QUANT_ROUND_EN defined, SHALL add 2^(RECIP_W-1) to the product before the shift, giving round half up.
REQ-027 Without QUANT_ROUND_EN, SHALL use the bare arithmetic shift, giving floor.

Structure
REQ-028 Package dct_pkg SHALL hold COEF_W/Q_W/RECIP_W defaults, the 64-entry RECIP and ZZ constant arrays, and the state enum.
REQ-029 Sub-module coef_quant SHALL perform one multiply/round/shift/saturate, instantiated 8 times, once per column.

Verification
REQ-030 Row 0 = {160,55,0,...}, other rows 0, out_ready=1 -> index0=10 (4096 recip), index1=5 (5958 recip), remaining 62 outputs 0, out_last at index 63.
REQ-031 Zigzag order: row1 c0=160 (Q=12, recip 5461), all else 0 -> out_index 2 = 13 (floor) or 13 (round); row7 c7=990 (recip 662) -> out_index 63 = 10 with out_last=1.
REQ-032 Saturation: c[0][0]=2047 -> index0=127 with out_sat=0 (no QUANT_ROUND_EN) or 127 with out_sat=1 (with QUANT_ROUND_EN); c[0][0]=-2048 -> -128, out_sat=0.
REQ-033 Backpressure: drop out_ready for 3 cycles at out_index 5 -> out_index, out_coef and out_valid held; all 64 outputs delivered exactly once.
REQ-034 Reset at out_index 30 -> next cycle out_valid=0 and in_ready=1; a fresh 8-row block drains correctly from index 0.
REQ-035 Back-to-back blocks with in_valid held high -> in_ready=0 for exactly 64 transfer cycles between blocks; second block's rows 0..7 accepted in order.
